// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register in front of the EX-stage ALU of the MIPS150 core.
// It captures decoded fields, resolves operand forwarding from MEM and WB,
// and builds the final A/B operand pair and ALUop for the ALU. The next cycle
// sees these values directly. It supports downstream stall (hold), flush
// (bubble insertion) and WB refresh of operands that are held during a stall.
//
// Optional feature macro: OPSTAGE_PERF_EN
//   When defined, the stall_cnt and bubble_cnt performance counters and their
//   ports are added. When undefined, those ports are absent and the core
//   behaviour is unchanged.
//
// Parameters:
//   DW  datapath width (operands, register data)
//   RW  register address width
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake (in_ready is combinational)
//   flush               squash stage contents (branch/jump redirect)
//   ex_stall            EX cannot consume this cycle
//   rs/rt/rd_addr       source and destination register numbers
//   rs_data, rt_data    register-file read data
//   imm16, shamt        instruction immediate fields
//   opsel               operand-select encoding
//   alu_op_in           ALUop from decode
//   fwd_mem_*           MEM-stage writeback candidate (forwarding)
//   fwd_wb_*            WB-stage writeback (forwarding and held refresh)
//   A, B, ALUop         registered ALU operands and operation
//   rd_out              registered destination register
//   out_valid           A/B/ALUop hold a live instruction
//   stall_cnt           (OPSTAGE_PERF_EN) cycles with out_valid & ex_stall
//   bubble_cnt          (OPSTAGE_PERF_EN) edges loading ALU_XXX via bubble/flush
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic          ex_stall,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm16,
  input  logic [4:0]    shamt,
  input  logic [2:0]    opsel,
  input  logic [3:0]    alu_op_in,
  input  logic          fwd_mem_we,
  input  logic [RW-1:0] fwd_mem_addr,
  input  logic [DW-1:0] fwd_mem_data,
  input  logic          fwd_wb_we,
  input  logic [RW-1:0] fwd_wb_addr,
  input  logic [DW-1:0] fwd_wb_data,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [3:0]    ALUop,
  output logic [RW-1:0] rd_out,
`ifdef OPSTAGE_PERF_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   bubble_cnt,
`endif
  output logic          out_valid
);

  // Shared ALUop encodings
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  // Operand-select encodings
  localparam logic [2:0] OPSEL_RR    = 3'd0;
  localparam logic [2:0] OPSEL_RI_S  = 3'd1;
  localparam logic [2:0] OPSEL_RI_Z  = 3'd2;
  localparam logic [2:0] OPSEL_SHAMT = 3'd3;
  localparam logic [2:0] OPSEL_SHVAR = 3'd4;
  localparam logic [2:0] OPSEL_LUI   = 3'd5;

  // Which operand slot a held source register feeds
  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_A    = 2'd1,
    SLOT_B    = 2'd2
  } slot_e;

  function automatic logic [DW-1:0] sext16(input logic [15:0] v);
    return {{(DW-16){v[15]}}, v};
  endfunction

  function automatic logic [DW-1:0] zext16(input logic [15:0] v);
    return {{(DW-16){1'b0}}, v};
  endfunction

  function automatic logic [DW-1:0] zext5(input logic [4:0] v);
    return {{(DW-5){1'b0}}, v};
  endfunction

  // Register 0 is never forwarded; MEM is younger than WB so it wins.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] r,
    input logic [DW-1:0] raw,
    input logic          mem_we,
    input logic [RW-1:0] mem_addr,
    input logic [DW-1:0] mem_data,
    input logic          wb_we,
    input logic [RW-1:0] wb_addr,
    input logic [DW-1:0] wb_data
  );
    if (r == '0)                         return raw;
    else if (mem_we && (mem_addr == r))  return mem_data;
    else if (wb_we && (wb_addr == r))    return wb_data;
    else                                 return raw;
  endfunction

  // Stage registers
  logic [DW-1:0] r_a_p1;
  logic [DW-1:0] r_b_p1;
  logic [3:0]    r_op_p1;
  logic [RW-1:0] r_rd_p1;
  logic          r_vld_p1;
  logic [RW-1:0] r_rs_addr_p1;
  logic [RW-1:0] r_rt_addr_p1;
  slot_e         r_rs_slot_p1;
  slot_e         r_rt_slot_p1;
  logic          r_rs_mask_p1;

  // Capture-path wires
  logic [DW-1:0] w_rs_fwd;
  logic [DW-1:0] w_rt_fwd;
  logic          w_sra;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [3:0]    w_op;
  slot_e         w_rs_slot;
  slot_e         w_rt_slot;
  logic          w_rs_mask;

  // Refresh-path wires
  logic          w_wb_ok;
  logic          w_rs_hit;
  logic          w_rt_hit;
  logic [DW-1:0] w_rs_ref_val;
  logic [DW-1:0] w_a_ref;
  logic [DW-1:0] w_b_ref;

  logic          w_hold;
  logic          w_bubble;

  assign in_ready = ~r_vld_p1 | ~ex_stall;
  assign w_hold   = ~in_ready;
  assign w_bubble = flush | (in_ready & ~in_valid);

  assign w_rs_fwd = fwd_sel(rs_addr, rs_data, fwd_mem_we, fwd_mem_addr,
                            fwd_mem_data, fwd_wb_we, fwd_wb_addr, fwd_wb_data);
  assign w_rt_fwd = fwd_sel(rt_addr, rt_data, fwd_mem_we, fwd_mem_addr,
                            fwd_mem_data, fwd_wb_we, fwd_wb_addr, fwd_wb_data);

  assign w_sra = (alu_op_in == ALU_SRA);

  // ---------------- p0 -> p1 : operand build ----------------
  // Shifts normally put the shifted value in A and the amount in B; SRA is
  // wired the other way round in the ALU, so its operands are swapped here.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_op      = alu_op_in;
    w_rs_slot = SLOT_NONE;
    w_rt_slot = SLOT_NONE;
    w_rs_mask = 1'b0;
    case (opsel)
      OPSEL_RR: begin
        w_a       = w_rs_fwd;
        w_b       = w_rt_fwd;
        w_rs_slot = SLOT_A;
        w_rt_slot = SLOT_B;
      end
      OPSEL_RI_S: begin
        w_a       = w_rs_fwd;
        w_b       = sext16(imm16);
        w_rs_slot = SLOT_A;
      end
      OPSEL_RI_Z: begin
        w_a       = w_rs_fwd;
        w_b       = zext16(imm16);
        w_rs_slot = SLOT_A;
      end
      OPSEL_SHAMT: begin
        if (w_sra) begin
          w_a       = zext5(shamt);
          w_b       = w_rt_fwd;
          w_rt_slot = SLOT_B;
        end else begin
          w_a       = w_rt_fwd;
          w_b       = zext5(shamt);
          w_rt_slot = SLOT_A;
        end
      end
      OPSEL_SHVAR: begin
        w_rs_mask = 1'b1;
        if (w_sra) begin
          w_a       = zext5(w_rs_fwd[4:0]);
          w_b       = w_rt_fwd;
          w_rs_slot = SLOT_A;
          w_rt_slot = SLOT_B;
        end else begin
          w_a       = w_rt_fwd;
          w_b       = zext5(w_rs_fwd[4:0]);
          w_rs_slot = SLOT_B;
          w_rt_slot = SLOT_A;
        end
      end
      OPSEL_LUI: begin
        w_a = zext16(imm16);
        w_b = '0;
      end
      default: begin
        w_a  = '0;
        w_b  = '0;
        w_op = ALU_XXX;
      end
    endcase
  end

  // While held, a WB write to a held source rewrites the operand it feeds.
  // Only WB refreshes: a MEM value may still be superseded before it retires.
  assign w_wb_ok  = fwd_wb_we && (fwd_wb_addr != '0);
  assign w_rs_hit = w_wb_ok && (fwd_wb_addr == r_rs_addr_p1) && (r_rs_slot_p1 != SLOT_NONE);
  assign w_rt_hit = w_wb_ok && (fwd_wb_addr == r_rt_addr_p1) && (r_rt_slot_p1 != SLOT_NONE);
  assign w_rs_ref_val = r_rs_mask_p1 ? zext5(fwd_wb_data[4:0]) : fwd_wb_data;

  always_comb begin
    w_a_ref = r_a_p1;
    w_b_ref = r_b_p1;
    if (w_rs_hit) begin
      if (r_rs_slot_p1 == SLOT_A) w_a_ref = w_rs_ref_val;
      else                        w_b_ref = w_rs_ref_val;
    end
    if (w_rt_hit) begin
      if (r_rt_slot_p1 == SLOT_A) w_a_ref = fwd_wb_data;
      else                        w_b_ref = fwd_wb_data;
    end
  end

  // ---------------- p1 : stage register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_op_p1      <= ALU_XXX;
      r_rd_p1      <= '0;
      r_rs_addr_p1 <= '0;
      r_rt_addr_p1 <= '0;
      r_rs_slot_p1 <= SLOT_NONE;
      r_rt_slot_p1 <= SLOT_NONE;
      r_rs_mask_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1     <= 1'b0;
      r_op_p1      <= ALU_XXX;
      r_rd_p1      <= '0;
      r_rs_slot_p1 <= SLOT_NONE;
      r_rt_slot_p1 <= SLOT_NONE;
    end else if (w_hold) begin
      r_a_p1 <= w_a_ref;
      r_b_p1 <= w_b_ref;
    end else if (in_valid) begin
      r_vld_p1     <= 1'b1;
      r_a_p1       <= w_a;
      r_b_p1       <= w_b;
      r_op_p1      <= w_op;
      r_rd_p1      <= rd_addr;
      r_rs_addr_p1 <= rs_addr;
      r_rt_addr_p1 <= rt_addr;
      r_rs_slot_p1 <= w_rs_slot;
      r_rt_slot_p1 <= w_rt_slot;
      r_rs_mask_p1 <= w_rs_mask;
    end else begin
      r_vld_p1     <= 1'b0;
      r_op_p1      <= ALU_XXX;
      r_rs_slot_p1 <= SLOT_NONE;
      r_rt_slot_p1 <= SLOT_NONE;
    end
  end

  assign A         = r_a_p1;
  assign B         = r_b_p1;
  assign ALUop     = r_op_p1;
  assign rd_out    = r_rd_p1;
  assign out_valid = r_vld_p1;

`ifdef OPSTAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_vld_p1 && ex_stall) r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (w_bubble)             r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  logic w_unused;
  assign w_unused = w_bubble;
`endif

endmodule
